ring_client_arb: RTL and testbench
==================================

Name: ring_client_arb

Overview:
Shares one ring node client port between NREQ local requesters (SPI bridge, debug port, on-chip agents). The transmit side merges requests with round-robin arbitration into a one-entry output register. The receive side routes each incoming ring word to the requester named by its tag field, with a timeout that discards words nobody accepts. It sits between the ring node client interface and the local agents, so every agent sees a private valid/ready channel.

Parameters:
NREQ, 4, number of local requesters (2..8)
CW, 14, client word width (same as ring node client word)
TBITS, 2, tag field width, word bits [CW-1 -: TBITS]; requires 2**TBITS >= NREQ
TIMEOUT, 255, cycles an undelivered rx word is held before it is dropped (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  requester i has a word to transmit
req_data  in  NREQ*CW  transmit words, requester i at [i*CW +: CW]
req_ready  out  NREQ  requester i word accepted this cycle
rsp_valid  out  NREQ  word available for requester i (one-hot or zero)
rsp_data  out  CW  received word, shared by all requesters
rsp_ready  in  NREQ  requester i accepts rsp_data
node_txdata  out  CW  word to ring node
node_txvalid  out  1  node_txdata valid
node_txready  in  1  ring node accepts word (transfer when valid&ready)
node_rxdata  in  CW  word from ring node
node_rxvalid  in  1  ring node holds a received word
node_rxack  out  1  one-cycle pulse: word consumed or dropped
drop_count  out  8  saturating count of dropped rx words

Behaviour:
- Reset (async, rst=1): all outputs 0. Tx register empty, rx FSM IDLE, round-robin pointer = 0, drop_count = 0, timeout counter = 0.
- Tx register: one entry, with node_txvalid = full. It loads when empty, or when it drains in the same cycle (txvalid&txready), so throughput is one word per cycle.
- Arbitration (rr_arbiter): on a load cycle, grant the first asserted req_valid at or after pointer, modulo NREQ. Drive req_ready[grant]=1 for that cycle only, latch req_data of the grantee, and set pointer = grant+1 mod NREQ.
- With no load, req_ready is all 0 and the pointer holds.
- The word passes unmodified; the requester supplies the tag. Latency is req accept to node_txvalid = 1 cycle.
- node_txdata is stable while node_txvalid=1 and txready=0.
- Rx FSM states: IDLE, DELIVER, ACK.
  - IDLE: on node_rxvalid, capture tag t = node_rxdata[CW-1 -: TBITS] and the word into the rx register, clear the timer, then go to DELIVER. If t >= NREQ, go straight to ACK as a drop instead.
  - DELIVER: rsp_valid[t]=1 and rsp_data = captured word. If rsp_ready[t]=1, go to ACK. Otherwise increment the timer; when timer == TIMEOUT, drop and go to ACK. rsp_ready on any other index is ignored.
  - ACK: node_rxack=1 for exactly one cycle, rsp_valid=0, then IDLE. node_rxvalid is not sampled in ACK, which gives the node one cycle to lower rxvalid.
- Drop: drop_count increments by 1 and saturates at 255.
- If delivery and timeout coincide (rsp_ready[t] in the cycle timer reaches TIMEOUT), delivery wins and there is no drop.
- Tx and rx paths are fully independent; simultaneous activity is allowed.
- A reset mid-transaction discards the tx word and the rx word with no ack; the node re-presents any word it still holds.

Decomposition:
- Package ring_pkg holds:
  - CW and TBITS defaults
  - tag field position constants
  - rx state encoding (IDLE=2'd0, DELIVER=2'd1, ACK=2'd2)
- Sub-module rr_arbiter (NREQ), combinational: inputs are the request vector and pointer; outputs are a one-hot grant and its index. The pointer register lives in the parent.

Test Plan:
- Single requester: req_valid=0001, data=14'h0A5, txready=1 → req_ready[0] pulses once; node_txvalid=1 the next cycle with txdata=14'h0A5.
- Round-robin fairness: all four req_valid held, txready=1 → grants in order 0,1,2,3,0 on consecutive cycles, one word per cycle.
- Tx backpressure: txready=0 for 5 cycles with the register full → req_ready stays 0 and node_txdata is unchanged. On release, the drain and next load happen in the same cycle.
- Rx routing: rxdata tag=2, rsp_ready[2] asserted 3 cycles later → rsp_valid=0100 for 4 cycles, then node_rxack pulses exactly once, drop_count=0.
- Timeout and bad tag (NREQ=3): tag=3 → immediate ack, drop_count=1. Next, tag=1 with rsp_ready=0 and TIMEOUT=4 → ack after the timeout, drop_count=2. Ready arriving in the same cycle as the timeout delivers, with no drop.
- Async reset: assert rst during DELIVER and while the tx register is full → all outputs 0 immediately. After release, the pointer=0 ordering resumes and drop_count=0.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the ring node client arbiter: default widths,
// tag field position helpers and the receive-side state encoding.
package ring_pkg;

    // Default client word width and tag width.
    localparam int RING_CW    = 14;
    localparam int RING_TBITS = 2;

    // Receive FSM encoding.
    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_DELIVER = 2'd1,
        RX_ACK     = 2'd2
    } rx_state_t;

    // Tag occupies the top tbits of a cw-bit word.
    function automatic int tag_msb(input int cw);
        return cw - 1;
    endfunction

    function automatic int tag_lsb(input int cw, input int tbits);
        return cw - tbits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after the pointer, wrapping modulo NREQ. The pointer lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ring_client_arb.sv
// Shares one ring node client port between NREQ local requesters.
// Tx: round-robin merge into a one-entry output register.
// Rx: route each received word to the requester named by its tag, dropping
// words that are not accepted within TIMEOUT cycles or carry a bad tag.
module ring_client_arb
    import ring_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CW      = RING_CW,
    parameter int TBITS   = RING_TBITS,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*CW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [CW-1:0]        rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [CW-1:0]        node_txdata,
    output logic                 node_txvalid,
    input  logic                 node_txready,
    input  logic [CW-1:0]        node_rxdata,
    input  logic                 node_rxvalid,
    output logic                 node_rxack,
    output logic [7:0]           drop_count
);

    localparam int PW = $clog2(NREQ);

    // ---------------- transmit side ----------------
    logic [CW-1:0]   w_req_word [NREQ];
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_idx;
    logic            w_any;
    logic            w_load;
    logic [PW-1:0]   w_ptr_next;

    logic            r_tx_full;
    logic [CW-1:0]   r_tx_data;
    logic [PW-1:0]   r_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_word
            assign w_req_word[gi] = req_data[gi*CW +: CW];
        end
    endgenerate

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // The register can take a new word when empty or draining this cycle.
    assign w_load     = !r_tx_full || node_txready;
    assign w_ptr_next = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    // Accept strobe is gated by reset so every output reads 0 while held.
    assign req_ready  = (w_load && w_any && !rst) ? w_grant : '0;

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_full <= 1'b0;
            r_tx_data <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            r_tx_full <= w_any;
            if (w_any) begin
                r_tx_data <= w_req_word[w_idx];
                r_ptr     <= w_ptr_next;
            end
        end
    end

    assign node_txvalid = r_tx_full;
    assign node_txdata  = r_tx_data;

    // ---------------- receive side ----------------
    logic [TBITS-1:0] w_rx_tag;
    logic             w_rsp_take;

    rx_state_t        r_state;
    logic [CW-1:0]    r_rx_data;
    logic [NREQ-1:0]  r_rsp_valid;
    logic             r_rxack;
    logic [7:0]       r_timer;
    logic [7:0]       r_drop_count;

    assign w_rx_tag   = node_rxdata[tag_msb(CW) -: TBITS];
    // r_rsp_valid is one-hot on the target, so this only sees rsp_ready[tag].
    assign w_rsp_take = |(rsp_ready & r_rsp_valid);

    // Rx FSM with registered rsp_valid / rxack and the saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_rx_data    <= '0;
            r_rsp_valid  <= '0;
            r_rxack      <= 1'b0;
            r_timer      <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    r_rxack <= 1'b0;
                    if (node_rxvalid) begin
                        r_rx_data <= node_rxdata;
                        r_timer   <= '0;
                        if (int'(w_rx_tag) < NREQ) begin
                            r_rsp_valid <= NREQ'(1) << w_rx_tag;
                            r_state     <= RX_DELIVER;
                        end else begin
                            // Nobody owns this tag: drop immediately.
                            if (r_drop_count != 8'hFF)
                                r_drop_count <= r_drop_count + 8'd1;
                            r_rxack <= 1'b1;
                            r_state <= RX_ACK;
                        end
                    end
                end
                RX_DELIVER: begin
                    if (w_rsp_take) begin
                        // Delivery wins even in the final timeout cycle.
                        r_rsp_valid <= '0;
                        r_rxack     <= 1'b1;
                        r_state     <= RX_ACK;
                    end else if (r_timer == 8'(TIMEOUT - 1)) begin
                        if (r_drop_count != 8'hFF)
                            r_drop_count <= r_drop_count + 8'd1;
                        r_rsp_valid <= '0;
                        r_rxack     <= 1'b1;
                        r_state     <= RX_ACK;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                RX_ACK: begin
                    // rxvalid is not sampled here so the node can lower it.
                    r_rxack <= 1'b0;
                    r_state <= RX_IDLE;
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_rxack     <= 1'b0;
                    r_state     <= RX_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rx_data;
    assign node_rxack = r_rxack;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_ring_client_arb.sv
// Self-checking bench for ring_client_arb: a transaction-level model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_ring_client_arb;

    localparam int NREQ    = 4;
    localparam int CW      = 14;
    localparam int TBITS   = 3;
    localparam int TIMEOUT = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*CW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [CW-1:0]        rsp_data;
    logic [NREQ-1:0]      rsp_ready;
    logic [CW-1:0]        node_txdata;
    logic                 node_txvalid;
    logic                 node_txready;
    logic [CW-1:0]        node_rxdata;
    logic                 node_rxvalid;
    logic                 node_rxack;
    logic [7:0]           drop_count;

    ring_client_arb #(.NREQ(NREQ), .CW(CW), .TBITS(TBITS), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .node_txdata  (node_txdata),
        .node_txvalid (node_txvalid),
        .node_txready (node_txready),
        .node_rxdata  (node_rxdata),
        .node_rxvalid (node_rxvalid),
        .node_rxack   (node_rxack),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [CW-1:0] m_txq [$];   // words waiting in the output slot (0 or 1)
    int            m_ptr;       // next requester to favour
    bit            m_offer;     // an rx word is being offered
    int            m_tag;
    logic [CW-1:0] m_word;
    int            m_age;       // cycles the current word has been offered
    bit            m_ack;       // ack cycle in progress
    int            m_drops;

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int g;
        r = '0;
        if (!rst && (m_txq.size() == 0 || node_txready)) begin
            g = pick();
            if (g >= 0) r[g] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int g;
        int t;
        if (rst) begin
            m_txq.delete();
            m_ptr = 0; m_offer = 0; m_ack = 0; m_age = 0; m_drops = 0; m_tag = 0;
        end else begin
            g = pick();
            if (m_txq.size() == 0 || node_txready) begin
                if (m_txq.size() != 0) void'(m_txq.pop_front());
                if (g >= 0) begin
                    m_txq.push_back(req_data[g*CW +: CW]);
                    m_ptr = (g + 1) % NREQ;
                end
            end
            if (m_ack) begin
                m_ack = 0;
            end else if (m_offer) begin
                m_age++;
                if (rsp_ready[m_tag]) begin
                    m_offer = 0; m_ack = 1;
                end else if (m_age == TIMEOUT) begin
                    m_offer = 0; m_ack = 1;
                    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end
            end else if (node_rxvalid) begin
                t = int'(node_rxdata[CW-1 -: TBITS]);
                m_word = node_rxdata;
                if (t >= NREQ) begin
                    m_ack = 1;
                    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end else begin
                    m_offer = 1; m_tag = t; m_age = 0;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] ev;
        ev = '0;
        if (m_offer) ev[m_tag] = 1'b1;
        check("req_ready", req_ready, exp_ready());
        check("txvalid", node_txvalid, m_txq.size() != 0);
        if (m_txq.size() != 0) check("txdata", node_txdata, m_txq[0]);
        check("rsp_valid", rsp_valid, ev);
        if (m_offer) check("rsp_data", rsp_data, m_word);
        check("rxack", node_rxack, m_ack);
        check("drop_count", drop_count, m_drops);
        if (rst) begin
            check("rst_txdata", node_txdata, 0);
            check("rst_rsp_data", rsp_data, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_run(input logic [CW-1:0] w, input int ready_at,
                          output int vc, output int na, output int ack_at);
        int t;
        logic [NREQ-1:0] oh;
        t  = int'(w[CW-1 -: TBITS]);
        oh = '0;
        if (t < NREQ) oh[t] = 1'b1;
        node_rxdata  = w;
        node_rxvalid = 1'b1;
        vc = 0; na = 0; ack_at = -1;
        for (int c = 0; c < 12; c++) begin
            tick();
            rsp_ready = (c == ready_at) ? oh : ~oh;
            #1;
            if (rsp_valid != 0) vc++;
            if (node_rxack) begin
                na++;
                if (ack_at < 0) ack_at = c;
                node_rxvalid = 1'b0;
            end
        end
        rsp_ready = '0;
        $display("rx word %h ready_at %0d: valid_cycles %0d acks %0d ack_at %0d drops %0d",
                 w, ready_at, vc, na, ack_at, drop_count);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int vc, na, aa, idx;
        int rr_exp [5];
        logic [CW-1:0] w;
        rr_exp = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req_valid = '0; req_data = '0; rsp_ready = '0;
        node_txready = 1'b0; node_rxdata = '0; node_rxvalid = 1'b0;
        repeat (3) tick();
        check("reset_drop", drop_count, 0);
        check("reset_txvalid", node_txvalid, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0;

        // Round robin: all requesters, one word per cycle.
        for (int i = 0; i < NREQ; i++) req_data[i*CW +: CW] = CW'(14'h100 + i);
        req_valid = 4'b1111; node_txready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            idx = -1;
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) idx = j;
            check("rr_grant", idx, rr_exp[k]);
            $display("rr cycle %0d grant %0d txvalid %0d", k, idx, node_txvalid);
            tick();
        end
        req_valid = '0;
        tick(); tick();

        // Single requester.
        req_valid = 4'b0001; req_data[0 +: CW] = 14'h0A5;
        #1 check("single_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        check("single_txvalid", node_txvalid, 1);
        check("single_txdata", node_txdata, 14'h0A5);
        check("single_ready_off", req_ready, 0);
        $display("single: txdata %h", node_txdata);
        tick();
        check("single_drained", node_txvalid, 0);

        // Backpressure.
        node_txready = 1'b0;
        req_valid = 4'b0010; req_data[1*CW +: CW] = 14'h1234;
        #1 check("bp_first_ready", req_ready, 4'b0010);
        tick();
        req_data[1*CW +: CW] = 14'h0777;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready_held", req_ready, 0);
            check("bp_txdata_stable", node_txdata, 14'h1234);
            tick();
        end
        node_txready = 1'b1;
        #1 check("bp_release_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        #1 check("bp_next_txdata", node_txdata, 14'h0777);
        $display("backpressure: released, txdata %h", node_txdata);
        tick();

        // Rx plain delivery while tx traffic flows; wrong-index readies ignored.
        req_valid = 4'b0101;
        w = {3'd2, 11'h055};
        rx_run(w, 1, vc, na, aa);
        req_valid = '0;
        check("plain_vcycles", vc, 2);
        check("plain_acks", na, 1);
        check("plain_ack_at", aa, 2);
        check("plain_drops", drop_count, 0);

        // Ready arrives in the timeout cycle: delivered, no drop.
        w = {3'd2, 11'h321};
        rx_run(w, 3, vc, na, aa);
        check("coincide_vcycles", vc, 4);
        check("coincide_ack_at", aa, 4);
        check("coincide_drops", drop_count, 0);

        // Bad tag.
        w = {3'd5, 11'h0AA};
        rx_run(w, -1, vc, na, aa);
        check("badtag_vcycles", vc, 0);
        check("badtag_ack_at", aa, 0);
        check("badtag_acks", na, 1);
        check("badtag_drops", drop_count, 1);

        // Timeout.
        w = {3'd1, 11'h0BB};
        rx_run(w, -1, vc, na, aa);
        check("timeout_vcycles", vc, 4);
        check("timeout_ack_at", aa, 4);
        check("timeout_drops", drop_count, 2);

        // Saturation.
        w = {3'd7, 11'h001};
        for (int k = 0; k < 256; k++) rx_run(w, -1, vc, na, aa);
        check("sat_drops", drop_count, 255);

        // Async reset during DELIVER with the tx register full.
        node_txready = 1'b0;
        req_valid = 4'b0001; req_data[0 +: CW] = 14'h0111;
        node_rxdata = {3'd1, 11'h022}; node_rxvalid = 1'b1;
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        check("arst_req_ready", req_ready, 0);
        check("arst_txvalid", node_txvalid, 0);
        check("arst_txdata", node_txdata, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_rxack", node_rxack, 0);
        check("arst_drops", drop_count, 0);
        $display("async reset: txvalid %0d rsp_valid %b drops %0d", node_txvalid, rsp_valid, drop_count);
        tick(); tick();
        rst = 1'b0;
        req_valid = 4'b1111; node_txready = 1'b1;
        #1 check("post_rst_grant", req_ready, 4'b0001);
        w = {3'd1, 11'h022};
        rx_run(w, 0, vc, na, aa);
        req_valid = '0;
        check("post_rst_vcycles", vc, 1);
        check("post_rst_ack_at", aa, 1);
        check("post_rst_drops", drop_count, 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
